// File: rtl/keypad_memory_controller.sv
// Keypad-written 16x4 register memory with a two-digit seven-segment display of read data and address.
// Write lands 3 cycles after dav is first sampled high; no backpressure, and a new dav edge outside IDLE is ignored.
module keypad_memory_controller #(
    parameter logic RW_WRITE_LEVEL = 1'b0,
    parameter int   SEG_ACTIVE_LOW = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dav,
    input  logic [3:0] KeypadData,
    input  logic [3:0] AddressIn,
    input  logic       RWin,
    input  logic       clock500Hz,
    output logic [3:0] DataOut,
    output logic [6:0] seg,
    output logic [1:0] digitSel,
    output logic       wrDone
);

    typedef enum logic [1:0] {IDLE, WRITE, ACK, WAIT_LOW} state_t;

    localparam logic [6:0] SEG_RESET  = (SEG_ACTIVE_LOW != 0) ? 7'h40 : ~7'h40;
    localparam logic [1:0] DSEL_DATA  = (SEG_ACTIVE_LOW != 0) ? 2'b10 : 2'b01;
    localparam logic [1:0] DSEL_ADDR  = ~DSEL_DATA;

    state_t     state;
    state_t     next_state;
    logic [3:0] mem [16];
    logic       s1, s2, s3;
    logic       r1, r2, r3;
    logic       dav_edge;
    logic       ref_edge;
    logic       toggle;
    logic [3:0] lat_addr;
    logic [3:0] lat_data;
    logic       latch_en;
    logic       mem_we;
    logic [3:0] disp_val;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0: p = 7'h40;
            4'h1: p = 7'h79;
            4'h2: p = 7'h24;
            4'h3: p = 7'h30;
            4'h4: p = 7'h19;
            4'h5: p = 7'h12;
            4'h6: p = 7'h02;
            4'h7: p = 7'h78;
            4'h8: p = 7'h00;
            4'h9: p = 7'h10;
            4'hA: p = 7'h08;
            4'hB: p = 7'h03;
            4'hC: p = 7'h46;
            4'hD: p = 7'h21;
            4'hE: p = 7'h06;
            default: p = 7'h0E;
        endcase
        return (SEG_ACTIVE_LOW != 0) ? p : ~p;
    endfunction

    // dav and the refresh strobe are both asynchronous: two sync flops plus one delay flop each
    always_ff @(posedge clock) begin
        if (reset) begin
            {s1, s2, s3} <= 3'b000;
            {r1, r2, r3} <= 3'b000;
        end else begin
            s1 <= dav;
            s2 <= s1;
            s3 <= s2;
            r1 <= clock500Hz;
            r2 <= r1;
            r3 <= r2;
        end
    end

    assign dav_edge = s2 & ~s3;
    assign ref_edge = r2 & ~r3;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (dav_edge) next_state = (RWin == RW_WRITE_LEVEL) ? WRITE : WAIT_LOW;
            WRITE:    next_state = ACK;
            ACK:      next_state = WAIT_LOW;
            WAIT_LOW: if (!s2) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        latch_en = (state == IDLE) && dav_edge && (RWin == RW_WRITE_LEVEL);
        mem_we   = (state == WRITE);
        wrDone   = (state == ACK);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lat_addr <= '0;
            lat_data <= '0;
        end else if (latch_en) begin
            lat_addr <= AddressIn;
            lat_data <= KeypadData;
        end
    end

    // DataOut samples memory before this edge's write, so a fresh write shows one cycle later
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= '0;
            end
            DataOut <= '0;
        end else begin
            DataOut <= mem[AddressIn];
            if (mem_we) begin
                mem[lat_addr] <= lat_data;
            end
        end
    end

    assign disp_val = toggle ? AddressIn : DataOut;

    always_ff @(posedge clock) begin
        if (reset) begin
            toggle   <= 1'b0;
            seg      <= SEG_RESET;
            digitSel <= DSEL_DATA;
        end else begin
            toggle   <= toggle ^ ref_edge;
            seg      <= hex7(disp_val);
            digitSel <= toggle ? DSEL_ADDR : DSEL_DATA;
        end
    end

endmodule

// File: tb/tb_keypad_memory_controller.sv
// Bench for keypad_memory_controller: cycle-indexed behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized keypad/refresh traffic.
module tb_keypad_memory_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       dav;
    logic [3:0] KeypadData;
    logic [3:0] AddressIn;
    logic       RWin;
    logic       clock500Hz;
    logic [3:0] DataOut;
    logic [6:0] seg;
    logic [1:0] digitSel;
    logic       wrDone;

    int checks = 0;
    int errors = 0;

    keypad_memory_controller dut (
        .clock      (clock),
        .reset      (reset),
        .dav        (dav),
        .KeypadData (KeypadData),
        .AddressIn  (AddressIn),
        .RWin       (RWin),
        .clock500Hz (clock500Hz),
        .DataOut    (DataOut),
        .seg        (seg),
        .digitSel   (digitSel),
        .wrDone     (wrDone)
    );

    always #5 clock = ~clock;

    logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: events are scheduled by cycle number relative to the sampled input edges
    logic [3:0] mem_m [16];
    logic [3:0] m_dout;
    logic [6:0] m_seg;
    logic [1:0] m_dsel;
    logic       m_wr;
    logic       m_toggle;
    logic       prev_dav;
    logic       prev_ref;
    logic [3:0] w_addr;
    logic [3:0] w_data;
    int         cyc;
    int         cap_at;
    int         wr_at;
    int         flip_at;
    bit         model_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] nd;
        logic [6:0] ns;
        logic [1:0] nsel;
        if (reset) begin
            for (int i = 0; i < 16; i++) mem_m[i] = 4'h0;
            m_dout = 4'h0; m_seg = 7'h40; m_dsel = 2'b10; m_wr = 1'b0; m_toggle = 1'b0;
            prev_dav = 1'b0; prev_ref = 1'b0;
            cyc = 0; cap_at = -1; wr_at = -1; flip_at = -1;
            model_valid = 1'b1;
        end else begin
            nd   = mem_m[AddressIn];
            ns   = hex_tbl[m_toggle ? AddressIn : m_dout];
            nsel = m_toggle ? 2'b01 : 2'b10;
            m_wr = (wr_at == cyc);
            if (wr_at == cyc) mem_m[w_addr] = w_data;
            if (cap_at == cyc && RWin == 1'b0) begin
                w_addr = AddressIn;
                w_data = KeypadData;
                wr_at  = cyc + 1;
            end
            if (dav && !prev_dav) cap_at = cyc + 2;
            if (flip_at == cyc) m_toggle = !m_toggle;
            if (clock500Hz && !prev_ref) flip_at = cyc + 2;
            prev_dav = dav;
            prev_ref = clock500Hz;
            m_dout = nd; m_seg = ns; m_dsel = nsel;
            cyc++;
        end
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    always @(negedge clock) begin
        if (model_valid) begin
            check("model_dataout", 32'(DataOut), 32'(m_dout));
            check("model_seg", 32'(seg), 32'(m_seg));
            check("model_digitsel", 32'(digitSel), 32'(m_dsel));
            check("model_wrdone", 32'(wrDone), 32'(m_wr));
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic rand_ref();
        if ($urandom_range(0, 2) == 0) clock500Hz = ~clock500Hz;
    endtask

    initial begin
        int cnt;
        int len;
        int gap;
        reset = 1'b1; dav = 1'b0; KeypadData = 4'h0; AddressIn = 4'h0; RWin = 1'b0; clock500Hz = 1'b0;
        repeat (3) tick();
        check("rst_dataout", 32'(DataOut), 32'h0);
        check("rst_seg", 32'(seg), 32'h40);
        check("rst_digitsel", 32'(digitSel), 32'h2);
        check("rst_wrdone", 32'(wrDone), 32'h0);
        reset = 1'b0;
        tick();

        // write 5 to address 3: wrDone exactly in cycle N+3, DataOut at N+4
        AddressIn = 4'h3; RWin = 1'b0; KeypadData = 4'h5; dav = 1'b1;
        tick();
        dav = 1'b0;
        tick(); tick();
        check("wr_wrdone_n2", 32'(wrDone), 32'h0);
        tick();
        check("wr_wrdone_n3", 32'(wrDone), 32'h1);
        tick();
        check("wr_wrdone_n4", 32'(wrDone), 32'h0);
        check("wr_dataout_n4", 32'(DataOut), 32'h5);
        repeat (4) tick();

        // read-mode dav: no write, no wrDone
        RWin = 1'b1; KeypadData = 4'h9; dav = 1'b1;
        tick();
        dav = 1'b0; cnt = 0;
        repeat (10) begin tick(); cnt += int'(wrDone); end
        check("rd_wrdone_count", 32'(cnt), 32'h0);
        check("rd_dataout", 32'(DataOut), 32'h5);
        RWin = 1'b0;

        // dav held 1000 cycles with changing data: one write of the value present at edge N+2
        AddressIn = 4'h4; KeypadData = 4'h0; dav = 1'b1; cnt = 0;
        for (int i = 1; i <= 1000; i++) begin
            tick();
            cnt += int'(wrDone);
            KeypadData = 4'(i);
        end
        dav = 1'b0;
        repeat (8) begin tick(); cnt += int'(wrDone); end
        check("hold_wrdone_count", 32'(cnt), 32'h1);
        check("hold_mem4", 32'(DataOut), 32'h2);

        // address changes after latching: data still lands at the latched address
        AddressIn = 4'h3; KeypadData = 4'hB; dav = 1'b1;
        tick();
        dav = 1'b0;
        tick(); tick();
        AddressIn = 4'h7;
        repeat (5) tick();
        check("latch_mem7", 32'(DataOut), 32'h0);
        AddressIn = 4'h3;
        repeat (2) tick();
        check("latch_mem3", 32'(DataOut), 32'hB);

        // display: DataOut = A, AddressIn = F, step the digit with two refresh edges
        AddressIn = 4'hF; KeypadData = 4'hA; dav = 1'b1;
        tick();
        dav = 1'b0;
        repeat (8) tick();
        check("disp0_digitsel", 32'(digitSel), 32'h2);
        check("disp0_seg", 32'(seg), 32'h08);
        clock500Hz = 1'b1;
        repeat (5) tick();
        check("disp1_digitsel", 32'(digitSel), 32'h1);
        check("disp1_seg", 32'(seg), 32'h0E);
        clock500Hz = 1'b0;
        repeat (3) tick();
        clock500Hz = 1'b1;
        repeat (5) tick();
        check("disp2_digitsel", 32'(digitSel), 32'h2);
        check("disp2_seg", 32'(seg), 32'h08);
        clock500Hz = 1'b0;
        repeat (3) tick();

        // reset while in WRITE: write aborted, memory cleared
        AddressIn = 4'h1; KeypadData = 4'h6; dav = 1'b1;
        tick();
        dav = 1'b0;
        tick(); tick();
        reset = 1'b1; cnt = 0;
        repeat (2) begin tick(); cnt += int'(wrDone); end
        reset = 1'b0;
        repeat (6) begin tick(); cnt += int'(wrDone); end
        check("abort_wrdone_count", 32'(cnt), 32'h0);
        for (int a = 0; a < 16; a++) begin
            AddressIn = 4'(a);
            repeat (2) tick();
            check($sformatf("abort_mem%0d", a), 32'(DataOut), 32'h0);
        end

        // dav high across reset release: exactly one write
        AddressIn = 4'h2; KeypadData = 4'h3; RWin = 1'b0; dav = 1'b1; reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0; cnt = 0;
        repeat (20) begin tick(); cnt += int'(wrDone); end
        check("rstdav_wrdone_count", 32'(cnt), 32'h1);
        dav = 1'b0;
        repeat (4) tick();
        check("rstdav_mem2", 32'(DataOut), 32'h3);

        // randomized traffic against the model
        for (int t = 0; t < 300; t++) begin
            AddressIn  = 4'($urandom_range(0, 15));
            KeypadData = 4'($urandom_range(0, 15));
            RWin       = 1'($urandom_range(0, 1));
            dav        = 1'b1;
            len = $urandom_range(1, 6);
            repeat (len) begin
                tick();
                rand_ref();
                if ($urandom_range(0, 3) == 0) KeypadData = 4'($urandom_range(0, 15));
            end
            dav = 1'b0;
            gap = $urandom_range(4, 8);
            repeat (gap) begin
                tick();
                rand_ref();
                AddressIn = 4'($urandom_range(0, 15));
            end
        end
        repeat (6) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_memory_controller.md
KEYPAD_MEMORY_CONTROLLER -- requirements
Module: keypad_memory_controller

Interface
REQ-001 Parameter RW_WRITE_LEVEL, default 1'b0: RWin level that selects write mode; the other level selects read mode.
REQ-002 Parameter SEG_ACTIVE_LOW, default 1: 1 means seg and digitSel are active-low; 0 means both are inverted to active-high.
REQ-003 clock  in  1  system clock (50 MHz); the sole clock of the block; every flop is on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 dav  in  1  keypad data-available; asynchronous to this block.
REQ-006 KeypadData  in  4  key code; stable while dav is high.
REQ-007 AddressIn  in  4  memory address for both read and write.
REQ-008 RWin  in  1  write/read mode select, interpreted per RW_WRITE_LEVEL.
REQ-009 clock500Hz  in  1  display refresh strobe; treated as a data input and never used as a clock.
REQ-010 DataOut  out  4  registered read data, mem[AddressIn].
REQ-011 seg  out  7  seven-segment pattern, bit order gfedcba.
REQ-012 digitSel  out  2  one-hot digit enable: bit0 selects the data digit, bit1 selects the address digit.
REQ-013 wrDone  out  1  one-cycle pulse for each completed write.

Function
REQ-014 Storage SHALL be a 16 x 4 register array.
REQ-015 dav SHALL pass through two synchronizer flops (s1, s2) and a third delay flop (s3); davEdge = s2 AND NOT s3.
REQ-016 clock500Hz SHALL be synchronized the same way; its rising edge produces refEdge.
REQ-017 The FSM SHALL have exactly four states: IDLE, WRITE, ACK, WAIT_LOW.
REQ-018 IDLE: on davEdge with RWin equal to RW_WRITE_LEVEL, latch KeypadData and AddressIn and go to WRITE.
REQ-019 IDLE: on davEdge with RWin not equal to RW_WRITE_LEVEL, go to WAIT_LOW with no write and no wrDone.
REQ-020 WRITE: write the latched data to mem[latched address] and go to ACK.
REQ-021 ACK: hold wrDone high for this cycle only, then go to WAIT_LOW.
REQ-022 WAIT_LOW: return to IDLE when s2 is 0.
REQ-023 The latched address and data SHALL be used even if AddressIn, KeypadData or RWin change after latching.
REQ-024 davEdge occurring outside IDLE SHALL be ignored.
REQ-025 A dav held high SHALL produce exactly one write; a further write requires dav to go low and then high again.
REQ-026 Latency: if dav is first sampled high at edge N, the FSM SHALL leave IDLE at edge N+2, memory SHALL update at edge N+3, and wrDone SHALL be high between edges N+3 and N+4.
REQ-027 DataOut SHALL be registered every cycle from mem[AddressIn] with 1-cycle latency.
REQ-028 A write to the currently addressed location SHALL appear on DataOut at edge N+4.
REQ-029 A digit toggle register SHALL invert on each refEdge.
REQ-030 Toggle = 0: digitSel selects bit0 and seg shows hex(DataOut); toggle = 1: digitSel selects bit1 and seg shows hex(AddressIn).
REQ-031 seg and digitSel SHALL be registered, updating one cycle after a toggle or value change.
REQ-032 Active-low hex patterns: 0 = 7'h40, 1 = 7'h79, 5 = 7'h12, 9 = 7'h10, A = 7'h08, F = 7'h0E; all 16 codes are decoded.

Reset
REQ-033 While reset is high, the FSM SHALL go to IDLE and any in-progress write SHALL be aborted.
REQ-034 On reset, all 16 memory words, DataOut, the latches, all synchronizer flops and the digit toggle SHALL clear to 0.
REQ-035 On reset, wrDone SHALL be 0, digitSel SHALL be the data digit (2'b10 active-low) and seg SHALL be 7'h40.
REQ-036 A dav held high across reset release SHALL produce exactly one write, because the synchronizer flops reset to 0.

Verification
REQ-037 Reset, then AddressIn = 3, RWin = 0, KeypadData = 5, pulse dav -> wrDone high exactly one cycle at N+3; DataOut = 5 at N+4.
REQ-038 RWin = 1, KeypadData = 9, dav pulse at address 3 -> no wrDone; DataOut remains 5.
REQ-039 Hold dav high for 1000 cycles with KeypadData changing -> exactly one wrDone; memory holds the value latched at N+2.
REQ-040 Change AddressIn 3 -> 7 at edge N+3 of a write -> data lands in mem[3]; mem[7] unchanged.
REQ-041 Two clock500Hz rising edges with DataOut = A and AddressIn = F -> digitSel 2'b01 with seg 7'h0E, then 2'b10 with seg 7'h08.
REQ-042 Assert reset while in WRITE -> no wrDone pulse; all memory words read 0 afterwards.
